// File: rtl/approx_adder_err_monitor_pkg.sv
// approx_adder_err_monitor_pkg: shared state encoding, default sizes and
// accumulator width formulas for the approximate-adder error monitor.
package approx_adder_err_monitor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NSAMP_W = 16;
  // N samples of at most 2^(w+1)-1 each cannot exceed w+1+n bits
  function automatic int acc_width(input int w, input int n);
    return w + 1 + n;
  endfunction
  function automatic int sq_width(input int w, input int n);
    return 2 * (w + 1) + n;
  endfunction
endpackage

// File: rtl/approx_err_dist.sv
// approx_err_dist: exact sum of a and b and its absolute distance to the
// approximate sum.
//   a, b    in  WIDTH    operands
//   approx  in  WIDTH+1  approximate sum {cout,s}
//   ed      out WIDTH+1  |(a+b) - approx|
module approx_err_dist #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   ed
);
  logic [WIDTH:0] exact;
  assign exact = {1'b0, a} + {1'b0, b};
  assign ed = exact >= approx ? exact - approx : approx - exact;
endmodule

// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: accumulates error statistics of an approximate
// adder over a run of num_samples samples.
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_samples  begin a run of N samples (taken in IDLE or DONE)
//   in_valid, in_ready  sample handshake
//   in_a, in_b          operands; in_approx is the approximate {cout,s}
//   busy, done          run in progress / statistics final
//   sample_cnt, err_count, sum_abs_err, max_abs_err  live statistics
//   sum_sq_err          sum of squared error, only when APPROX_ERR_MSE_EN
//                       is defined (adds one pipeline stage to done)
module approx_adder_err_monitor
  import approx_adder_err_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSAMP_W = DEF_NSAMP_W,
  localparam int ACC_W = acc_width(WIDTH, NSAMP_W)
`ifdef APPROX_ERR_MSE_EN
  ,localparam int SQ_W = sq_width(WIDTH, NSAMP_W)
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSAMP_W-1:0] num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH:0]     in_approx,
  output logic               busy,
  output logic               done,
  output logic [NSAMP_W-1:0] sample_cnt,
  output logic [NSAMP_W-1:0] err_count,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [WIDTH:0]     max_abs_err
`ifdef APPROX_ERR_MSE_EN
  ,output logic [SQ_W-1:0]   sum_sq_err
`endif
);
  state_t state;
  logic [NSAMP_W-1:0] n_left;
  logic [WIDTH:0] ed, ed1;
  logic v1, accept, clear, drained;
  assign accept = in_valid & in_ready;
  assign clear = start && (state == ST_IDLE || state == ST_DONE);
  assign busy = state == ST_RUN || state == ST_DRAIN;
  assign done = state == ST_DONE;
  approx_err_dist #(.WIDTH(WIDTH)) u_dist (
    .a(in_a),
    .b(in_b),
    .approx(in_approx),
    .ed(ed)
  );
`ifdef APPROX_ERR_MSE_EN
  logic v2;
  logic [2*WIDTH+1:0] sq2;
  assign drained = !v1 && !v2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= 1'b0;
      sq2 <= '0;
      sum_sq_err <= '0;
    end else begin
      v2 <= v1;
      sq2 <= ed1 * ed1;
      if (clear) sum_sq_err <= '0;
      else if (v2) sum_sq_err <= sum_sq_err + SQ_W'(sq2);
    end
`else
  assign drained = !v1;
`endif
  // in_ready is registered from the remaining-sample count, never from in_valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      n_left <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state <= num_samples == '0 ? ST_DONE : ST_RUN;
          n_left <= num_samples;
          in_ready <= num_samples != '0;
        end
        ST_RUN: if (accept) begin
          n_left <= n_left - NSAMP_W'(1);
          if (n_left == NSAMP_W'(1)) begin
            in_ready <= 1'b0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (drained) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      ed1 <= '0;
      sample_cnt <= '0;
      err_count <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else begin
      v1 <= accept;
      ed1 <= ed;
      if (clear) begin
        sample_cnt <= '0;
        err_count <= '0;
        sum_abs_err <= '0;
        max_abs_err <= '0;
      end else if (v1) begin
        sample_cnt <= sample_cnt + NSAMP_W'(1);
        err_count <= err_count + NSAMP_W'(ed1 != '0);
        sum_abs_err <= sum_abs_err + ACC_W'(ed1);
        if (ed1 > max_abs_err) max_abs_err <= ed1;
      end
    end
endmodule
